uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in baud.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rxd  input  1  serial receive line, asynchronous to clk, idle high.
REQ-006 SHALL have port rx_data  output  8  last received byte, LSB first on the wire.
REQ-007 SHALL have port rx_data_valid  output  1  one-cycle pulse: rx_data holds a new, correctly framed byte.
REQ-008 SHALL have port rx_busy  output  1  high while a frame is in progress (any state except IDLE).
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-010 SHALL define BPS_CNT = CLK_FREQ/BAUD_RATE (integer division) and MID_CNT = BPS_CNT/2.
REQ-011 SHALL pass rxd through a two-flop synchronizer (both flops reset to 1) before any use; a third flop SHALL hold the previous synchronized value for edge detection.
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 IDLE: on a synchronized falling edge (previous 1, current 0) SHALL clear the 16-bit clk_cnt and go to START.
REQ-014 START: clk_cnt SHALL count up; at clk_cnt == MID_CNT-1, if synchronized rxd is 0 SHALL clear clk_cnt and bit_cnt and go to DATA, else SHALL return to IDLE (glitch reject, no outputs pulsed).
REQ-015 DATA: clk_cnt SHALL wrap at BPS_CNT-1; on each wrap SHALL sample synchronized rxd into shift register bit position bit_cnt and increment bit_cnt (4-bit); after the 8th sample SHALL go to STOP with clk_cnt cleared.
REQ-016 STOP: at clk_cnt == BPS_CNT-1 (mid stop bit) SHALL sample rxd and return to IDLE on the same edge.
REQ-017 Stop sample 1: SHALL load rx_data from the shift register and pulse rx_data_valid for exactly one cycle, on the cycle after the stop sample.
REQ-018 Stop sample 0: SHALL pulse frame_err for one cycle on the cycle after the stop sample, leave rx_data unchanged and not pulse rx_data_valid.
REQ-019 rx_data SHALL hold its value until the next valid frame completes.
REQ-020 Return to IDLE at mid stop bit SHALL allow a back-to-back frame start edge to be detected with no idle gap.
REQ-021 A framing error followed by rxd held low (break) SHALL NOT start a new frame until rxd returns high and falls again.
REQ-022 rx_data_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-023 On rst high at a clk edge: state IDLE, clk_cnt 0, bit_cnt 0, shift register 0, rx_data 8'h00, rx_data_valid 0, frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-024 Reset mid-frame SHALL abort the frame with no valid or error pulse; reception SHALL resume on the next falling edge after rst deasserts.

Structure
REQ-025 SHALL place the state enumeration and the BPS_CNT/MID_CNT derivation in the shared uart package used by the transmitter.
REQ-026 SHALL be a single module; the optional sub-module is sync_2ff (two-flop synchronizer), shared with other asynchronous inputs.

Verification (CLK_FREQ 50 MHz, BAUD_RATE 115200, BPS_CNT 434)
REQ-027 Send 0x55 with a valid stop bit -> one rx_data_valid pulse, rx_data = 8'h55, frame_err stays 0.
REQ-028 Send 0xA3 then 0x0F back-to-back with no idle gap -> two valid pulses, 8'hA3 then 8'h0F.
REQ-029 Drive rxd low for 100 cycles, then high -> no pulses, rx_busy falls by cycle 217, state IDLE.
REQ-030 Send 0x3C with stop bit 0 -> one frame_err pulse, no valid pulse, rx_data keeps its previous value.
REQ-031 Assert rst for 1 cycle during data bit 4 of 0x96, then send 0x81 -> no pulse for 0x96, one valid pulse with 8'h81.
REQ-032 Hold rxd low after a framing error for 2000 cycles, then idle high and send 0x7E -> exactly one frame_err, then valid 8'h7E.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART state encoding and baud-divider derivation.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Clocks per bit, truncating toward zero.
    function automatic int unsigned bps_cnt(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned mid_cnt(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
        return bps_cnt(clk_freq, baud_rate) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for a single asynchronous input.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, framing-error detection.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam logic [15:0] c_BPS_LAST = 16'(bps_cnt(CLK_FREQ, BAUD_RATE)) - 16'd1;
    localparam logic [15:0] c_MID_LAST = 16'(mid_cnt(CLK_FREQ, BAUD_RATE)) - 16'd1;

    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic [15:0] r_clk_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_valid;
    logic        r_err;
    logic        w_rxd;
    logic        r_rxd_prev;
    logic        w_fall;
    logic        w_bit_tick;
    logic        w_mid_tick;
    logic        w_busy;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rxd (
        .clk     (clk),
        .rst     (rst),
        .i_async (rxd),
        .o_sync  (w_rxd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_prev <= w_rxd;
        end
    end

    // A held-low break never looks like a new edge until the line recovers.
    assign w_fall     = r_rxd_prev & ~w_rxd;
    assign w_bit_tick = (r_clk_cnt == c_BPS_LAST);
    assign w_mid_tick = (r_clk_cnt == c_MID_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_fall) w_state_nxt = ST_START;
            ST_START: if (w_mid_tick) w_state_nxt = w_rxd ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_bit_tick && (r_bit_cnt == 4'd7)) w_state_nxt = ST_STOP;
            ST_STOP:  if (w_bit_tick) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_rx_data <= 8'h00;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) r_clk_cnt <= 16'd0;
                end
                ST_START: begin
                    if (w_mid_tick) begin
                        r_clk_cnt <= 16'd0;
                        r_bit_cnt <= 4'd0;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        r_clk_cnt                 <= 16'd0;
                        r_shift[r_bit_cnt[2:0]]   <= w_rxd;
                        r_bit_cnt                 <= r_bit_cnt + 4'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= 16'd0;
                        if (w_rxd) begin
                            r_rx_data <= r_shift;
                            r_valid   <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: r_clk_cnt <= 16'd0;
            endcase
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_data_valid = r_valid;
    assign frame_err     = r_err;
    assign rx_busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Scoreboard-based bench for uart_rx at 50 MHz / 115200 baud.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_BPS = 434;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_busy;
    logic       frame_err;

    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic [7:0] model_last;

    uart_rx #(
        .CLK_FREQ  (50000000),
        .BAUD_RATE (115200)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_busy       (rx_busy),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rxd = b;
        repeat (c_BPS - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        if (stop) begin
            e.is_err   = 1'b0;
            e.data     = d;
            model_last = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = model_last;
        end
        sb_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_data_valid && frame_err) chk("pulse_overlap", 1, 0);
            if (rx_data_valid || frame_err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, rx_data_valid, frame_err}, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_at;
        int fall_at;
        checks     = 0;
        errors     = 0;
        model_last = 8'h00;
        rst        = 1'b1;
        rxd        = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 0);
        chk("reset_busy", {31'd0, rx_busy}, 0);
        chk("reset_valid", {31'd0, rx_data_valid}, 0);
        chk("reset_ferr", {31'd0, frame_err}, 0);
        idle(20);

        send_frame(8'h55, 1'b1);
        idle(500);

        // Back-to-back: next start bit directly follows the stop bit.
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(500);

        // Short low glitch must be rejected at mid start bit.
        rise_at = -1;
        fall_at = -1;
        @(negedge clk);
        rxd = 1'b0;
        for (int n = 1; n < 1000; n++) begin
            @(negedge clk);
            if (n == 100) rxd = 1'b1;
            if (rx_busy && rise_at < 0) rise_at = n;
            if (!rx_busy && rise_at >= 0 && fall_at < 0) fall_at = n;
        end
        chk("glitch_busy_len", fall_at - rise_at, 217);
        chk("glitch_idle", {31'd0, rx_busy}, 0);
        idle(100);

        send_frame(8'h3C, 1'b0);
        idle(500);

        // Reset during data bit 4 of 0x96; sender abandons the frame.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h96 >> i));
        @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 8'h00;
        @(negedge clk);
        chk("midreset_busy", {31'd0, rx_busy}, 0);
        chk("midreset_rx_data", {24'd0, rx_data}, 0);
        idle(2 * c_BPS);
        send_frame(8'h81, 1'b1);
        idle(500);

        // Framing error followed by a long break.
        send_frame(8'hC5, 1'b0);
        @(negedge clk);
        rxd = 1'b0;
        repeat (2000) @(negedge clk);
        chk("break_busy", {31'd0, rx_busy}, 0);
        idle(2 * c_BPS);
        send_frame(8'h7E, 1'b1);
        idle(1000);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
